// File: rtl/fp_stream_pkg.sv
// Shared constants for the FP32 result stream: word width and IEEE-754 single field layout.
package fp_stream_pkg;

    localparam int unsigned FP_DATA_W   = 32;

    localparam int unsigned FP_SIGN_BIT = 31;
    localparam int unsigned FP_EXP_MSB  = 30;
    localparam int unsigned FP_EXP_LSB  = 23;
    localparam int unsigned FP_MANT_MSB = 22;
    localparam int unsigned FP_MANT_LSB = 0;

    localparam int unsigned FP_EXP_W    = FP_EXP_MSB - FP_EXP_LSB + 1;
    localparam int unsigned FP_MANT_W   = FP_MANT_MSB - FP_MANT_LSB + 1;

    localparam logic [FP_EXP_W-1:0] EXP_ALL_ONES = '1;
    localparam logic [FP_EXP_W-1:0] EXP_ZERO     = '0;

endpackage

// File: rtl/fp32_classify.sv
// Combinational FP32 classifier: flags NaN, infinity and signed/unsigned zero.
module fp32_classify
    import fp_stream_pkg::*;
(
    input  logic [FP_DATA_W-1:0] word,
    output logic                 is_nan,
    output logic                 is_inf,
    output logic                 is_zero
);

    logic [FP_EXP_W-1:0]  exp_f;
    logic [FP_MANT_W-1:0] mant_f;
    logic [FP_DATA_W-1:0] magnitude;

    always_comb begin
        exp_f                  = word[FP_EXP_MSB:FP_EXP_LSB];
        mant_f                 = word[FP_MANT_MSB:FP_MANT_LSB];
        // Zero ignores the sign bit, so -0.0 classifies the same as +0.0.
        magnitude              = word;
        magnitude[FP_SIGN_BIT] = 1'b0;

        is_nan  = (exp_f == EXP_ALL_ONES) && (mant_f != '0);
        is_inf  = (exp_f == EXP_ALL_ONES) && (mant_f == '0);
        is_zero = (magnitude == '0);
    end

endmodule

// File: rtl/fp_result_sink.sv
// FIFO sink for an AXI-Stream FP32 result channel with beat counter and sticky classification flags.
module fp_result_sink
    import fp_stream_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DATA_W = FP_DATA_W
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [DATA_W-1:0]        s_axis_result_tdata,
    input  logic                     s_axis_result_tvalid,
    output logic                     s_axis_result_tready,
    input  logic                     clr,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              result_count,
    output logic                     nan_seen,
    output logic                     inf_seen,
    output logic                     zero_seen
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W  = ADDR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [15:0]       count_q, count_d;
    logic              nan_q, nan_d;
    logic              inf_q, inf_d;
    logic              zero_q, zero_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;

    logic accept;
    logic pop;
    logic cls_nan, cls_inf, cls_zero;

    fp32_classify u_classify (
        .word    (s_axis_result_tdata[FP_DATA_W-1:0]),
        .is_nan  (cls_nan),
        .is_inf  (cls_inf),
        .is_zero (cls_zero)
    );

    always_comb begin
        full                 = (level_q == LVL_W'(DEPTH));
        empty                = (level_q == '0);
        // rstn in tready keeps the sink closed while reset is asserted, before any edge.
        s_axis_result_tready = !full && !clr && rstn;
        accept               = s_axis_result_tvalid && s_axis_result_tready;
        pop                  = rd_en && !empty && !clr;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        count_d    = count_q;
        nan_d      = nan_q;
        inf_d      = inf_q;
        zero_d     = zero_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;

        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            count_d  = '0;
            nan_d    = 1'b0;
            inf_d    = 1'b0;
            zero_d   = 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                count_d  = count_q + 16'd1;
                nan_d    = nan_q  | cls_nan;
                inf_d    = inf_q  | cls_inf;
                zero_d   = zero_q | cls_zero;
            end
            if (pop) begin
                rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
                rd_data_d  = mem_q[rd_ptr_q];
                rd_valid_d = 1'b1;
            end
            case ({accept, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            count_q    <= '0;
            nan_q      <= 1'b0;
            inf_q      <= 1'b0;
            zero_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            count_q    <= count_d;
            nan_q      <= nan_d;
            inf_q      <= inf_d;
            zero_q     <= zero_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage is left unreset; the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= s_axis_result_tdata;
        end
    end

    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign level        = level_q;
    assign result_count = count_q;
    assign nan_seen     = nan_q;
    assign inf_seen     = inf_q;
    assign zero_seen    = zero_q;

endmodule

// File: tb/tb_fp_result_sink.sv
// Scoreboard bench for fp_result_sink: ordering, backpressure, empty reads, clear and async reset.
module tb_fp_result_sink;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rstn;
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              clr;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [3:0]        level;
    logic [15:0]       result_count;
    logic              nan_seen;
    logic              inf_seen;
    logic              zero_seen;

    int checks   = 0;
    int failures = 0;

    logic [31:0] sb[$];
    int          m_level;
    logic [15:0] m_count;
    bit          m_nan, m_inf, m_zero;
    logic [31:0] m_rd_data;
    bit          m_rd_valid;

    fp_result_sink #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .s_axis_result_tdata  (tdata),
        .s_axis_result_tvalid (tvalid),
        .s_axis_result_tready (tready),
        .clr                  (clr),
        .rd_en                (rd_en),
        .rd_data              (rd_data),
        .rd_valid             (rd_valid),
        .empty                (empty),
        .full                 (full),
        .level                (level),
        .result_count         (result_count),
        .nan_seen             (nan_seen),
        .inf_seen             (inf_seen),
        .zero_seen            (zero_seen)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        sb.delete();
        m_level    = 0;
        m_count    = '0;
        m_nan      = 1'b0;
        m_inf      = 1'b0;
        m_zero     = 1'b0;
        m_rd_data  = '0;
        m_rd_valid = 1'b0;
    endfunction

    // Predict the effect of the current inputs at the next edge, then advance past it.
    task automatic tick();
        bit acc, pp;
        logic [7:0]  e;
        logic [22:0] m;
        acc = (rstn === 1'b1) && tvalid && !clr && (m_level < DEPTH);
        pp  = (rstn === 1'b1) && rd_en  && !clr && (m_level > 0);
        m_rd_valid = 1'b0;
        if (rstn !== 1'b1) begin
            model_reset();
        end else if (clr) begin
            sb.delete();
            m_level = 0;
            m_count = '0;
            m_nan   = 1'b0;
            m_inf   = 1'b0;
            m_zero  = 1'b0;
        end else begin
            if (pp) begin
                m_rd_data  = sb.pop_front();
                m_rd_valid = 1'b1;
            end
            if (acc) begin
                sb.push_back(tdata);
                m_count = m_count + 16'd1;
                e = tdata[30:23];
                m = tdata[22:0];
                if (e == 8'hFF && m != 0) m_nan  = 1'b1;
                if (e == 8'hFF && m == 0) m_inf  = 1'b1;
                if (e == 8'h00 && m == 0) m_zero = 1'b1;
            end
            m_level = m_level + int'(acc) - int'(pp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b1; tvalid = 1'b0; tdata = '0; clr = 1'b0; rd_en = 1'b0;
        #1 rstn = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (tready !== 1'b0) begin failures++; $display("FAIL rst_tready cyc%0d got=%0b exp=0", i, tready); end
            checks++; if (empty !== 1'b1 || level !== 4'd0) begin failures++; $display("FAIL rst_empty cyc%0d empty=%0b level=%0d exp 1/0", i, empty, level); end
        end
        rstn = 1'b1;
        tick();
        checks++; if (tready !== 1'b1) begin failures++; $display("FAIL rel_tready got=%0b exp=1", tready); end
        checks++; if (empty !== 1'b1 || full !== 1'b0 || level !== 4'd0) begin failures++; $display("FAIL rel_status empty=%0b full=%0b level=%0d exp 1/0/0", empty, full, level); end
        checks++; if (result_count !== 16'd0) begin failures++; $display("FAIL rel_count got=%0d exp=0", result_count); end
        checks++; if ({nan_seen, inf_seen, zero_seen, rd_valid} !== 4'b0) begin failures++; $display("FAIL rel_flags got=%b exp=0000", {nan_seen, inf_seen, zero_seen, rd_valid}); end
    endtask

    task automatic test_ordering();
        logic [31:0] words [3];
        words[0] = 32'h4000_0000; words[1] = 32'h3F00_0000; words[2] = 32'h7F80_0000;
        for (int i = 0; i < 3; i++) begin
            tdata = words[i]; tvalid = 1'b1;
            tick();
        end
        tvalid = 1'b0; rd_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (rd_valid !== 1'b1 || rd_data !== words[i]) begin failures++; $display("FAIL ord_pop%0d valid=%0b data=%08h exp 1/%08h", i, rd_valid, rd_data, words[i]); end
        end
        rd_en = 1'b0;
        tick();
        checks++; if (rd_valid !== 1'b0 || rd_data !== 32'h7F80_0000) begin failures++; $display("FAIL ord_hold valid=%0b data=%08h exp 0/7f800000", rd_valid, rd_data); end
        checks++; if (inf_seen !== 1'b1 || nan_seen !== 1'b0) begin failures++; $display("FAIL ord_flags inf=%0b nan=%0b exp 1/0", inf_seen, nan_seen); end
        checks++; if (result_count !== 16'd3 || empty !== 1'b1) begin failures++; $display("FAIL ord_count count=%0d empty=%0b exp 3/1", result_count, empty); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 8; i++) begin
            tdata = 32'h3F80_0000 + 32'(i); tvalid = 1'b1;
            tick();
        end
        tdata = 32'h4120_0000;
        checks++; if (full !== 1'b1 || tready !== 1'b0 || level !== 4'd8) begin failures++; $display("FAIL bp_full full=%0b tready=%0b level=%0d exp 1/0/8", full, tready, level); end
        tick();
        tick();
        checks++; if (level !== 4'd8 || result_count !== m_count) begin failures++; $display("FAIL bp_stall level=%0d count=%0d exp 8/%0d", level, result_count, m_count); end
        rd_en = 1'b1;
        tick();
        checks++; if (rd_valid !== m_rd_valid || rd_data !== m_rd_data) begin failures++; $display("FAIL bp_pop valid=%0b data=%08h exp %0b/%08h", rd_valid, rd_data, m_rd_valid, m_rd_data); end
        checks++; if (tready !== 1'b1 || level !== 4'd7) begin failures++; $display("FAIL bp_reopen tready=%0b level=%0d exp 1/7", tready, level); end
        rd_en = 1'b0;
        tick();
        tvalid = 1'b0;
        checks++; if (level !== 4'd8 || full !== 1'b1 || result_count !== 16'd12) begin failures++; $display("FAIL bp_ninth level=%0d full=%0b count=%0d exp 8/1/12", level, full, result_count); end
        rd_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (rd_valid !== m_rd_valid || rd_data !== m_rd_data) begin failures++; $display("FAIL bp_drain%0d valid=%0b data=%08h exp %0b/%08h", i, rd_valid, rd_data, m_rd_valid, m_rd_data); end
        end
        rd_en = 1'b0;
        checks++; if (rd_data !== 32'h4120_0000 || empty !== 1'b1) begin failures++; $display("FAIL bp_last data=%08h empty=%0b exp 41200000/1", rd_data, empty); end
    endtask

    task automatic test_back_to_back();
        tvalid = 1'b1;
        tdata = 32'h4040_0000; tick();
        tdata = 32'h4080_0000; tick();
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tdata = 32'h4100_0000 + 32'(i << 16);
            tick();
            checks++; if (rd_valid !== m_rd_valid || rd_data !== m_rd_data || level !== 4'd2) begin failures++; $display("FAIL b2b%0d valid=%0b data=%08h level=%0d exp %0b/%08h/2", i, rd_valid, rd_data, level, m_rd_valid, m_rd_data); end
        end
        tvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (rd_valid !== m_rd_valid || rd_data !== m_rd_data) begin failures++; $display("FAIL b2b_drain%0d valid=%0b data=%08h exp %0b/%08h", i, rd_valid, rd_data, m_rd_valid, m_rd_data); end
        end
        rd_en = 1'b0;
        checks++; if (empty !== 1'b1 || level !== 4'd0) begin failures++; $display("FAIL b2b_empty empty=%0b level=%0d exp 1/0", empty, level); end
    endtask

    task automatic test_empty_read();
        logic [31:0] held;
        held  = m_rd_data;
        rd_en = 1'b1; tvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (rd_valid !== 1'b0 || rd_data !== held || level !== 4'd0 || empty !== 1'b1) begin failures++; $display("FAIL er%0d valid=%0b data=%08h level=%0d empty=%0b exp 0/%08h/0/1", i, rd_valid, rd_data, level, empty, held); end
        end
        tdata = 32'h40A0_0000; tvalid = 1'b1;
        tick();
        checks++; if (rd_valid !== 1'b0 || level !== 4'd1) begin failures++; $display("FAIL er_nobypass valid=%0b level=%0d exp 0/1", rd_valid, level); end
        tvalid = 1'b0;
        tick();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 32'h40A0_0000) begin failures++; $display("FAIL er_next valid=%0b data=%08h exp 1/40a00000", rd_valid, rd_data); end
        rd_en = 1'b0;
        tick();
    endtask

    task automatic test_clear();
        tvalid = 1'b1;
        tdata = 32'h7FC0_0000; tick();
        tdata = 32'h8000_0000; tick();
        checks++; if (nan_seen !== 1'b1 || zero_seen !== 1'b1 || inf_seen !== m_inf) begin failures++; $display("FAIL clr_pre nan=%0b zero=%0b inf=%0b exp 1/1/%0b", nan_seen, zero_seen, inf_seen, m_inf); end
        clr = 1'b1; rd_en = 1'b1; tdata = 32'h3F80_0000;
        #1;
        checks++; if (tready !== 1'b0) begin failures++; $display("FAIL clr_tready got=%0b exp=0", tready); end
        tick();
        checks++; if (level !== 4'd0 || empty !== 1'b1 || result_count !== 16'd0) begin failures++; $display("FAIL clr_state level=%0d empty=%0b count=%0d exp 0/1/0", level, empty, result_count); end
        checks++; if ({nan_seen, inf_seen, zero_seen, rd_valid} !== 4'b0) begin failures++; $display("FAIL clr_flags got=%b exp=0000", {nan_seen, inf_seen, zero_seen, rd_valid}); end
        clr = 1'b0; tvalid = 1'b0; rd_en = 1'b0;
        tick();
        checks++; if (level !== 4'd0 || tready !== 1'b1) begin failures++; $display("FAIL clr_after level=%0d tready=%0b exp 0/1", level, tready); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            tdata = 32'h0000_0000 + 32'(i); tvalid = 1'b1;
            tick();
        end
        tvalid = 1'b0;
        checks++; if (level !== 4'd5) begin failures++; $display("FAIL ar_level got=%0d exp=5", level); end
        #2 rstn = 1'b0;
        model_reset();
        #1;
        checks++; if (level !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || tready !== 1'b0) begin failures++; $display("FAIL ar_status level=%0d empty=%0b full=%0b tready=%0b exp 0/1/0/0", level, empty, full, tready); end
        checks++; if (rd_valid !== 1'b0 || rd_data !== 32'h0 || result_count !== 16'd0) begin failures++; $display("FAIL ar_out valid=%0b data=%08h count=%0d exp 0/0/0", rd_valid, rd_data, result_count); end
        checks++; if ({nan_seen, inf_seen, zero_seen} !== 3'b0) begin failures++; $display("FAIL ar_flags got=%b exp=000", {nan_seen, inf_seen, zero_seen}); end
        tick();
        rstn = 1'b1;
        tick();
        checks++; if (empty !== 1'b1 || level !== 4'd0 || tready !== 1'b1) begin failures++; $display("FAIL ar_release empty=%0b level=%0d tready=%0b exp 1/0/1", empty, level, tready); end
        tdata = 32'hC2C8_0000; tvalid = 1'b1;
        tick();
        tvalid = 1'b0; rd_en = 1'b1;
        tick();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 32'hC2C8_0000 || m_rd_data !== 32'hC2C8_0000) begin failures++; $display("FAIL ar_fresh valid=%0b data=%08h exp 1/c2c80000", rd_valid, rd_data); end
        rd_en = 1'b0;
        tick();
        checks++; if (empty !== 1'b1 || rd_valid !== 1'b0) begin failures++; $display("FAIL ar_final empty=%0b valid=%0b exp 1/0", empty, rd_valid); end
    endtask

    initial begin
        test_reset();
        test_ordering();
        test_backpressure();
        test_back_to_back();
        test_empty_read();
        test_clear();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_result_sink.md
FP_RESULT_SINK -- requirements
Module: fp_result_sink

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the FIFO entries; it SHALL be a power of two, 2..64.
REQ-002 Parameter DATA_W, default 32, SHALL set the stream word width; it SHALL hold IEEE-754 single precision.
REQ-003 clk  input  1  SHALL be the single clock; all logic SHALL be on its rising edge.
REQ-004 rstn  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 s_axis_result_tdata  input  DATA_W  SHALL carry the divider result word.
REQ-006 s_axis_result_tvalid  input  1  SHALL mark the result word valid.
REQ-007 s_axis_result_tready  output  1  SHALL indicate the sink can accept a word.
REQ-008 clr  input  1  SHALL be a synchronous clear of the FIFO, counters and flags.
REQ-009 rd_en  input  1  SHALL request a pop of the FIFO.
REQ-010 rd_data  output  DATA_W  SHALL be the popped word, registered.
REQ-011 rd_valid  output  1  SHALL be a one-cycle strobe qualifying rd_data.
REQ-012 empty, full  output  1 each  SHALL be the FIFO status.
REQ-013 level  output  log2(DEPTH)+1  SHALL be the occupancy, 0..DEPTH.
REQ-014 result_count  output  16  SHALL count accepted beats.
REQ-015 nan_seen, inf_seen, zero_seen  output  1 each  SHALL be sticky classification flags.

Function
REQ-016 A beat SHALL be accepted only in a cycle where tvalid and tready are both 1.
REQ-017 tready SHALL be (!full && !clr && rstn), with no combinational path from tvalid.
REQ-018 An accepted word SHALL be written at the write pointer, and level SHALL increment the next cycle.
REQ-019 rd_en with !empty SHALL pop the oldest word; rd_data and rd_valid SHALL be presented the next cycle (1-cycle latency).
REQ-020 rd_en while empty SHALL be ignored: rd_valid=0, rd_data held, no pointer change.
REQ-021 rd_data SHALL hold its last value when no pop occurs.
REQ-022 A simultaneous accept and pop SHALL leave level unchanged, and order SHALL be preserved.
REQ-023 There SHALL be no write-to-read bypass: a word accepted while empty SHALL be poppable from the following cycle.
REQ-024 A pop while full SHALL raise tready in the next cycle; no beat SHALL be lost or duplicated.
REQ-025 Pointers SHALL wrap modulo DEPTH; full/empty SHALL be derived from a pointer extra MSB or from level.
REQ-026 result_count SHALL increment per accepted beat and wrap 0xFFFF->0x0000.
REQ-027 Classification of each accepted word SHALL be:
- NaN: exp==0xFF, mant!=0.
- Inf: exp==0xFF, mant==0.
- Zero: exp==0, mant==0, either sign.
REQ-028 Each matching class SHALL set its sticky flag the cycle after acceptance.
REQ-029 clr SHALL have priority over accept and pop in the same cycle: it SHALL empty the FIFO, zero level, result_count and all flags, and force rd_valid=0.

Reset
REQ-030 While rstn=0, the block SHALL immediately hold:
- pointers, level, result_count and flags = 0.
- rd_valid=0, rd_data=0, empty=1, full=0, tready=0.
REQ-031 Reset mid-operation SHALL discard all stored words; FIFO storage need not be cleared.

Structure
REQ-032 Package fp_stream_pkg SHALL hold:
- DATA_W default.
- FP32 field positions (sign 31, exp 30:23, mant 22:0).
- EXP_ALL_ONES, EXP_ZERO constants.
REQ-033 Combinational sub-module fp32_classify SHALL map a word to is_nan, is_inf, is_zero; FIFO storage and pointers SHALL remain in fp_result_sink.

Verification
REQ-034 Reset: hold rstn=0 for 3 cycles, then release -> during reset tready=0; after release tready=1, empty=1, level=0, result_count=0, flags 0.
REQ-035 Ordering: push 0x40000000, 0x3F000000, 0x7F800000 back-to-back, then rd_en for 3 cycles -> rd_data in the same order, each with rd_valid, inf_seen=1, nan_seen=0, result_count=3.
REQ-036 Backpressure: push 8 words with rd_en=0, then hold a 9th (0x41200000) valid -> full=1, tready=0, 9th not taken; one pop -> 9th accepted next cycle, level=8, no loss.
REQ-037 Empty read: rd_en=1 while empty -> rd_valid=0, level=0, pointers unchanged.
REQ-038 Clear: push 0x7FC00000 and 0x80000000 -> nan_seen=1, zero_seen=1; assert clr with tvalid=1 -> no accept, level=0, count=0, flags=0.
REQ-039 Async reset: drop rstn mid-cycle at level=5 -> outputs reach reset values before the next clk edge; FIFO empty after release.
